// File: rtl/bram_pkg.sv
// Shared widths and FSM encoding for the line BRAM write path.
package bram_pkg;

  localparam int BRAM_ADDR_WIDTH = 6;
  localparam int BRAM_DATA_WIDTH = 256;
  localparam int IN_WIDTH        = 32;
  localparam int WORDS_PER_LINE  = BRAM_DATA_WIDTH / IN_WIDTH;
  localparam int DEPTH           = 2 ** BRAM_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, FULL} packer_state_t;

endpackage

// File: rtl/bram_line_packer.sv
// Packs a narrow word stream into BRAM lines, writing each completed line at a
// wrapping pointer and refusing input while every line is still unconsumed.
module bram_line_packer
  import bram_pkg::packer_state_t, bram_pkg::IDLE, bram_pkg::FILL, bram_pkg::FULL;
#(
  parameter int BRAM_ADDR_WIDTH = bram_pkg::BRAM_ADDR_WIDTH,
  parameter int BRAM_DATA_WIDTH = bram_pkg::BRAM_DATA_WIDTH,
  parameter int IN_WIDTH        = bram_pkg::IN_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [IN_WIDTH-1:0]        in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       wr_en,
  output logic [BRAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [BRAM_DATA_WIDTH-1:0] wr_din,
  input  logic                       line_release,
  output logic [BRAM_ADDR_WIDTH:0]   lines_used,
  output logic                       full,
  output logic                       underflow
);

  localparam int W     = BRAM_DATA_WIDTH / IN_WIDTH;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(W - 1);
  localparam logic [BRAM_ADDR_WIDTH:0] DEPTH_CNT = (BRAM_ADDR_WIDTH + 1)'(2 ** BRAM_ADDR_WIDTH);
  localparam logic [BRAM_ADDR_WIDTH:0] ONE_CNT   = (BRAM_ADDR_WIDTH + 1)'(1);

  packer_state_t                state_q, state_d;
  logic [IDX_W-1:0]             word_idx_q, word_idx_d;
  logic [BRAM_DATA_WIDTH-1:0]   line_q, line_d, line_asm;
  logic [BRAM_ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [BRAM_ADDR_WIDTH:0]     lines_used_q, lines_used_d;
  logic                         underflow_q, underflow_d;
  logic                         wr_en_q;
  logic [BRAM_ADDR_WIDTH-1:0]   wr_addr_q;
  logic [BRAM_DATA_WIDTH-1:0]   wr_din_q;
  logic                         accept, commit, rel_ok;

  // Held low during reset so nothing is accepted into a line being discarded.
  assign full       = (lines_used_q == DEPTH_CNT);
  assign in_ready   = !reset && !full && (state_q != FULL);
  assign accept     = in_valid && in_ready;
  assign commit     = accept && ((word_idx_q == LAST_IDX) || in_last);
  assign rel_ok     = line_release && (lines_used_q != '0);

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_din     = wr_din_q;
  assign lines_used = lines_used_q;
  assign underflow  = underflow_q;

  always_comb begin
    line_asm = line_q;
    for (int k = 0; k < W; k++) begin
      if (word_idx_q == IDX_W'(k)) line_asm[k*IN_WIDTH +: IN_WIDTH] = in_data;
    end

    line_d      = line_q;
    word_idx_d  = word_idx_q;
    wr_ptr_d    = wr_ptr_q;
    if (commit) begin
      line_d     = '0;
      word_idx_d = '0;
      wr_ptr_d   = wr_ptr_q + BRAM_ADDR_WIDTH'(1);
    end else if (accept) begin
      line_d     = line_asm;
      word_idx_d = word_idx_q + IDX_W'(1);
    end

    lines_used_d = lines_used_q;
    case ({commit, rel_ok})
      2'b10:   lines_used_d = lines_used_q + ONE_CNT;
      2'b01:   lines_used_d = lines_used_q - ONE_CNT;
      default: lines_used_d = lines_used_q;
    endcase
    underflow_d = underflow_q | (line_release && (lines_used_q == '0));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FILL: begin
        if (commit)      state_d = (lines_used_d == DEPTH_CNT) ? FULL : IDLE;
        else if (accept) state_d = FILL;
      end
      FULL:    if (line_release) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      line_q       <= '0;
      wr_ptr_q     <= '0;
      lines_used_q <= '0;
      underflow_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_din_q     <= '0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      line_q       <= line_d;
      wr_ptr_q     <= wr_ptr_d;
      lines_used_q <= lines_used_d;
      underflow_q  <= underflow_d;
      wr_en_q      <= commit;
      if (commit) begin
        wr_addr_q <= wr_ptr_q;
        wr_din_q  <= line_asm;
      end
    end
  end

endmodule

// File: tb/tb_bram_line_packer.sv
// Directed and randomized bench for bram_line_packer with a queue-based line model.
module tb_bram_line_packer;

  localparam int AW    = 6;
  localparam int DW    = 256;
  localparam int IW    = 32;
  localparam int W     = DW / IW;
  localparam int DEPTH = 2 ** AW;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_din;
  logic          line_release;
  logic [AW:0]   lines_used;
  logic          full;
  logic          underflow;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int            m_used;
  int            m_ptr;
  bit            m_under;
  logic [IW-1:0] m_lanes[$];
  bit            exp_wr;
  int            exp_addr;
  logic [DW-1:0] exp_din;

  bram_line_packer #(
    .BRAM_ADDR_WIDTH(AW),
    .BRAM_DATA_WIDTH(DW),
    .IN_WIDTH(IW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_din(wr_din),
    .line_release(line_release),
    .lines_used(lines_used),
    .full(full),
    .underflow(underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit v, input logic [IW-1:0] d, input bit l, input bit r);
    in_valid     = v;
    in_data      = d;
    in_last      = l;
    line_release = r;
  endtask

  // One clock: check ready, advance the model on the current inputs, check outputs.
  task automatic cyc();
    bit m_ready, acc, commit, rel_ok;
    m_ready = (m_used < DEPTH);
    chk("in_ready", in_ready, m_ready);
    acc    = in_valid && m_ready;
    commit = 0;
    if (acc) begin
      m_lanes.push_back(in_data);
      if (m_lanes.size() == W || in_last) begin
        commit  = 1;
        exp_din = '0;
        foreach (m_lanes[i]) exp_din[i*IW +: IW] = m_lanes[i];
        exp_addr = m_ptr;
        m_ptr    = (m_ptr + 1) % DEPTH;
        m_lanes.delete();
      end
    end
    rel_ok = line_release && (m_used > 0);
    if (line_release && m_used == 0) m_under = 1;
    m_used = m_used + int'(commit) - int'(rel_ok);
    exp_wr = commit;
    @(posedge clock);
    #1;
    chk("wr_en", wr_en, exp_wr);
    if (exp_wr) begin
      chk("wr_addr", wr_addr, exp_addr);
      chk("wr_din", wr_din, exp_din);
    end
    chk("lines_used", lines_used, m_used);
    chk("full", full, (m_used == DEPTH));
    chk("underflow", underflow, m_under);
  endtask

  task automatic do_reset();
    drv(0, '0, 0, 0);
    reset = 1'b1;
    #2;
    chk("ready_in_reset", in_ready, 0);
    @(posedge clock);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_din", wr_din, 0);
    chk("rst_lines_used", lines_used, 0);
    chk("rst_full", full, 0);
    chk("rst_underflow", underflow, 0);
    reset = 1'b0;
    m_used  = 0;
    m_ptr   = 0;
    m_under = 0;
    m_lanes.delete();
    #1;
  endtask

  task automatic send_line();
    for (int k = 0; k < W; k++) begin
      drv(1, $urandom, 0, 0);
      cyc();
    end
  endtask

  initial begin
    logic          v, l, r;
    logic [IW-1:0] d;
    v = 0; l = 0; r = 0; d = '0;

    // Full line of 1..8
    do_reset();
    for (int k = 1; k <= W; k++) begin
      drv(1, k, 0, 0);
      cyc();
    end
    chk("full_line_wr_en", wr_en, 1);
    chk("full_line_addr", wr_addr, 0);
    chk("full_line_lane0", wr_din[31:0], 1);
    chk("full_line_lane7", wr_din[255:224], 8);
    chk("full_line_used", lines_used, 1);
    drv(0, '0, 0, 0);
    cyc();

    // Partial line terminated by in_last
    do_reset();
    drv(1, 32'hA, 0, 0); cyc();
    drv(1, 32'hB, 0, 0); cyc();
    drv(1, 32'hC, 1, 0); cyc();
    chk("partial_din", wr_din, {160'h0, 32'hC, 32'hB, 32'hA});
    chk("partial_addr", wr_addr, 0);
    drv(0, '0, 0, 0);
    cyc();

    // Randomized traffic, holding data while stalled
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!(v && m_used >= DEPTH)) begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
        l = ($urandom_range(0, 7) == 0);
      end
      r = ($urandom_range(0, 5) == 0);
      drv(v, d, l, r);
      cyc();
    end

    // Fill all lines, stall, release one, wrap
    do_reset();
    for (int n = 0; n < DEPTH; n++) send_line();
    chk("fill_full", full, 1);
    chk("fill_ready", in_ready, 0);
    for (int s = 0; s < 3; s++) begin
      drv(1, 32'hDEAD_BEEF, 0, 0);
      cyc();
    end
    drv(1, 32'hDEAD_BEEF, 0, 1);
    cyc();
    chk("release_ready", in_ready, 1);
    for (int k = 0; k < W; k++) begin
      drv(1, (k == 0) ? 32'hDEAD_BEEF : $urandom, 0, 0);
      cyc();
    end
    chk("wrap_wr_en", wr_en, 1);
    chk("wrap_addr", wr_addr, 0);
    drv(0, '0, 0, 0);
    cyc();

    // Commit and release in the same cycle at five lines
    do_reset();
    for (int n = 0; n < 5; n++) send_line();
    for (int k = 0; k < W - 1; k++) begin
      drv(1, $urandom, 0, 0);
      cyc();
    end
    drv(1, $urandom, 0, 1);
    cyc();
    chk("simul_wr_en", wr_en, 1);
    chk("simul_used", lines_used, 5);

    // Underflow is sticky and leaves the count at zero
    do_reset();
    drv(0, '0, 0, 1);
    cyc();
    chk("underflow_set", underflow, 1);
    chk("underflow_used", lines_used, 0);
    drv(0, '0, 0, 0);
    cyc();
    chk("underflow_sticky", underflow, 1);

    // Reset after four words discards the partial line
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(1, $urandom, 0, 0);
      cyc();
    end
    do_reset();
    drv(0, '0, 0, 0);
    cyc();
    chk("midreset_no_write", wr_en, 0);
    for (int k = 0; k < W; k++) begin
      drv(1, 32'h100 + k, 0, 0);
      cyc();
    end
    chk("midreset_addr", wr_addr, 0);
    chk("midreset_lane0", wr_din[31:0], 32'h100);
    drv(0, '0, 0, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram_line_packer.md
# bram_line_packer

Upstream write stage for the dual-address line BRAM. It accepts a narrow word stream on a valid/ready handshake and packs `WORDS_PER_LINE` words into one `BRAM_DATA_WIDTH` line. Each completed line is written to the BRAM at a wrapping write pointer. An occupancy counter, decremented by consumer release pulses, stops the packer from overwriting lines that have not yet been consumed.

## Interface
Parameters:
- `BRAM_ADDR_WIDTH`, 6: BRAM address width; `DEPTH = 2**BRAM_ADDR_WIDTH` lines.
- `BRAM_DATA_WIDTH`, 256: line width.
- `IN_WIDTH`, 32: input word width; `WORDS_PER_LINE = BRAM_DATA_WIDTH/IN_WIDTH`, which must be an exact power of two.

Ports:
- `clock`  in  1: single clock; all state updates on the posedge.
- `reset`  in  1: asynchronous, active-high.
- `in_valid`  in  1: input word valid.
- `in_data`  in  `IN_WIDTH`: input word.
- `in_last`  in  1: qualifies `in_data` as the final word of a frame; forces a line commit.
- `in_ready`  out  1: packer can accept a word.
- `wr_en`  out  1: one-cycle BRAM write strobe.
- `wr_addr`  out  `BRAM_ADDR_WIDTH`: BRAM write address.
- `wr_din`  out  `BRAM_DATA_WIDTH`: BRAM write data.
- `line_release`  in  1: consumer frees one line (one pulse per line).
- `lines_used`  out  `BRAM_ADDR_WIDTH+1`: committed, unreleased lines.
- `full`  out  1: `lines_used == DEPTH`.
- `underflow`  out  1: sticky; set when `line_release` arrives with `lines_used == 0`.

## Operation
- **Handshake.** A word transfers on a posedge with `in_valid && in_ready`.
  - `in_ready = !full && (state != FULL)`, combinational.
  - `in_data` must not change while `in_valid && !in_ready`.
- **Packing.** The accepted word k (k = 0..W-1, from `word_idx`) is stored in line bits `[k*IN_WIDTH +: IN_WIDTH]`, so word 0 occupies the LSBs.
- **Commit.** A commit occurs when the accepted word has `word_idx == W-1`, or when it has `in_last=1`.
  - Lanes not yet written in the current line are zero.
  - On the next cycle: `wr_en=1`, `wr_addr=wr_ptr`, `wr_din=` the assembled line.
  - `wr_ptr` increments modulo `DEPTH` (63 wraps to 0).
  - The assembly buffer clears and `word_idx` returns to 0.
- **Occupancy.**
  - `lines_used` +1 on commit and −1 on a valid release.
  - A commit and a release in the same cycle leave it unchanged.
  - A release at 0 is ignored and sets `underflow`.
- **FSM.**
  - IDLE (`word_idx=0`): an accept moves to FILL. An accept with `in_last` commits and stays in IDLE.
  - FILL: commit → FULL if the post-update `lines_used == DEPTH`, else IDLE.
  - FULL: `in_ready=0`. Any `line_release` → IDLE.
  - A commit that lands exactly at DEPTH also enters FULL from IDLE.
- **Reset mid-line.** The partial line is discarded. No write is issued.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_din=0`, `lines_used=0`, `full=0`, `underflow=0`, state IDLE, `word_idx=0`.
- `in_ready` is 0 while `reset` is asserted and 1 on the first cycle after deassertion.
- `wr_en`/`wr_addr`/`wr_din` are registered on the posedge and stable across the BRAM's negedge write.
- `wr_en` is high for exactly one cycle per line.
- Write latency is one cycle from the completing accept to `wr_en`.
- Throughput is 1 word/cycle, including back-to-back lines with no bubble at the commit.
- `lines_used` and `full` update on the same posedge that raises `wr_en`.
- Consequently `in_ready` drops in the cycle immediately after the committing word when that commit fills the BRAM.

## Structure
- Shared package `bram_pkg`:
  - `BRAM_ADDR_WIDTH`, `BRAM_DATA_WIDTH`, `IN_WIDTH`, and derived `WORDS_PER_LINE` and `DEPTH`.
  - `typedef enum logic [1:0] {IDLE, FILL, FULL} packer_state_t`.
- Single module; no sub-module. The occupancy counter is inline.

## Test plan
- **Full line.** Reset, then 8 words 0x00000001..0x00000008 back-to-back → one `wr_en` pulse on the cycle after word 8; `wr_addr=0`; `wr_din[31:0]=1`, `wr_din[255:224]=8`; `lines_used=1`.
- **Partial line.** 3 words 0xA,0xB,0xC with `in_last` on 0xC → `wr_din` = {160'h0, 32'hC, 32'hB, 32'hA}; `wr_addr=0`.
- **Fill and stall.** Stream 64 full lines with no release → `full=1`, `in_ready=0` after line 64. One `line_release` → `in_ready=1`, and the next line writes at `wr_addr=0` (wrap).
- **Simultaneous commit and release.** Commit and `line_release` in the same cycle with `lines_used=5` → stays 5.
- **Underflow.** `line_release` at `lines_used=0` → `underflow=1` (sticky), count stays 0.
- **Reset mid-line.** Assert `reset` after word 4 of a line → no `wr_en`. The next 8 words write a clean line at `wr_addr=0`.
